// File: rtl/branch_predictor_btb_pkg.sv
// rtl/branch_predictor_btb_pkg.sv - shared encodings and counter helper for the BTB predictor
package branch_predictor_btb_pkg;

    typedef enum logic [2:0] {
        NOB = 3'd0,
        BEQ = 3'd1,
        BNE = 3'd2,
        BLT = 3'd3,
        BGE = 3'd4
    } branch_t;

    typedef enum logic [1:0] {
        NOJ  = 2'd0,
        JAL  = 2'd1,
        JALR = 2'd2
    } jump_t;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_REL  = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        if (taken) begin
            sat_update = (ctr == ST) ? ST : ctr_t'(ctr + 2'd1);
        end else begin
            sat_update = (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
        end
    endfunction

endpackage

// File: rtl/btb_array.sv
// rtl/btb_array.sv - direct-mapped BTB storage, two combinational read ports, one write port
module btb_array
    import branch_predictor_btb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = XLEN - 2 - IDX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] f_idx_i,
    output logic                f_valid_o,
    output logic [TAG_BITS-1:0] f_tag_o,
    output logic [XLEN-1:0]     f_target_o,
    output logic [1:0]          f_ctr_o,
    input  logic [IDX_BITS-1:0] e_idx_i,
    output logic                e_valid_o,
    output logic [TAG_BITS-1:0] e_tag_o,
    output logic [XLEN-1:0]     e_target_o,
    output logic [1:0]          e_ctr_o,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] w_idx_i,
    input  logic                w_valid_i,
    input  logic [TAG_BITS-1:0] w_tag_i,
    input  logic [XLEN-1:0]     w_target_i,
    input  logic [1:0]          w_ctr_i
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic                valid_q  [DEPTH];
    logic [TAG_BITS-1:0] tag_q    [DEPTH];
    logic [XLEN-1:0]     target_q [DEPTH];
    logic [1:0]          ctr_q    [DEPTH];

    // Reads see the pre-write contents; there is deliberately no write bypass.
    assign f_valid_o  = valid_q[f_idx_i];
    assign f_tag_o    = tag_q[f_idx_i];
    assign f_target_o = target_q[f_idx_i];
    assign f_ctr_o    = ctr_q[f_idx_i];
    assign e_valid_o  = valid_q[e_idx_i];
    assign e_tag_o    = tag_q[e_idx_i];
    assign e_target_o = target_q[e_idx_i];
    assign e_ctr_o    = ctr_q[e_idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (we_i) begin
            valid_q[w_idx_i]  <= w_valid_i;
            tag_q[w_idx_i]    <= w_tag_i;
            target_q[w_idx_i] <= w_target_i;
            ctr_q[w_idx_i]    <= w_ctr_i;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - fetch-stage BTB predictor with execute-stage resolution and training
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    output logic            predTakenF,
    output logic [XLEN-1:0] predTargetF,
    input  logic            validE,
    input  logic [2:0]      branchE,
    input  logic [1:0]      jumpE,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            predTakenE,
    input  logic [XLEN-1:0] predTargetE,
    output logic            mispredictE,
    output logic [XLEN-1:0] redirectPCE,
    output logic [31:0]     branchCount,
    output logic [31:0]     mispredCount
);

    localparam int TAG_BITS = XLEN - 2 - IDX_BITS;

    logic [IDX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0] tag_f, tag_e;
    logic                f_valid, e_valid;
    logic [TAG_BITS-1:0] f_tag, e_tag;
    logic [XLEN-1:0]     f_target, e_target;
    logic [1:0]          f_ctr, e_ctr;
    logic                hit_f, hit_e, ctrl_e, taken_e, active_e;
    logic                we;
    logic                w_valid;
    logic [XLEN-1:0]     w_target;
    logic [1:0]          w_ctr;
    logic [31:0]         branch_count_q, branch_count_d;
    logic [31:0]         mispred_count_q, mispred_count_d;
    logic                unused_pc_bits;

    assign idx_f = PCF[IDX_BITS+1:2];
    assign tag_f = PCF[XLEN-1:IDX_BITS+2];
    assign idx_e = PCE[IDX_BITS+1:2];
    assign tag_e = PCE[XLEN-1:IDX_BITS+2];
    assign unused_pc_bits = ^PCE[1:0];

    btb_array #(
        .XLEN     (XLEN),
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_btb_array (
        .clk        (clk),
        .rst        (rst),
        .f_idx_i    (idx_f),
        .f_valid_o  (f_valid),
        .f_tag_o    (f_tag),
        .f_target_o (f_target),
        .f_ctr_o    (f_ctr),
        .e_idx_i    (idx_e),
        .e_valid_o  (e_valid),
        .e_tag_o    (e_tag),
        .e_target_o (e_target),
        .e_ctr_o    (e_ctr),
        .we_i       (we),
        .w_idx_i    (idx_e),
        .w_valid_i  (w_valid),
        .w_tag_i    (tag_e),
        .w_target_i (w_target),
        .w_ctr_i    (w_ctr)
    );

    assign hit_f       = f_valid & (f_tag == tag_f);
    assign hit_e       = e_valid & (e_tag == tag_e);
    assign predTakenF  = ~rst & hit_f & f_ctr[1];
    assign predTargetF = predTakenF ? f_target : PCF + XLEN'(4);

    assign ctrl_e   = (branchE != NOB) | (jumpE != NOJ);
    assign taken_e  = (PCSrcE != PCSRC_SEQ);
    assign active_e = validE & ~rst;

    always_comb begin
        mispredictE = 1'b0;
        redirectPCE = PCPlus4E;
        if (active_e) begin
            if (!ctrl_e) begin
                // A taken prediction on a non-branch is a stale alias; fall through to PC+4.
                mispredictE = predTakenE;
            end else begin
                if (jumpE == JALR) begin
                    mispredictE = 1'b1;
                end else begin
                    mispredictE = (taken_e != predTakenE) |
                                  (taken_e & (predTargetE != PCTargetE));
                end
                redirectPCE = taken_e ? PCTargetE : PCPlus4E;
            end
        end
    end

    always_comb begin
        we       = 1'b0;
        w_valid  = 1'b1;
        w_target = e_target;
        w_ctr    = e_ctr;
        if (active_e) begin
            if (ctrl_e && (jumpE != JALR)) begin
                if (hit_e) begin
                    we       = 1'b1;
                    w_target = taken_e ? PCTargetE : e_target;
                    w_ctr    = sat_update(ctr_t'(e_ctr), taken_e);
                end else if (taken_e) begin
                    we       = 1'b1;
                    w_target = PCTargetE;
                    w_ctr    = (jumpE == JAL) ? ST : WT;
                end
            end else if (!ctrl_e && predTakenE && hit_e) begin
                we      = 1'b1;
                w_valid = 1'b0;
            end
        end
    end

    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (active_e) begin
            branch_count_d  = branch_count_q + {31'd0, ctrl_e};
            mispred_count_d = mispred_count_q + {31'd0, mispredictE};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign branchCount  = branch_count_q;
    assign mispredCount = mispred_count_q;

endmodule
